// File: rtl/xilinx_primitive_pkg.sv
// Shared types and helpers for the synchronous primitive wrappers.
package xilinx_primitive_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_rd_mode_e;

    // Count/pointer width: one extra bit so a full FIFO (count == depth) is representable.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/xilinx_fifo_sync_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module xilinx_fifo_sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register doubles as the FIFO's DO, so it carries the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/xilinx_fifo_sync.sv
// Single-clock FIFO with occupancy count, registered flags and standard or FWFT read mode.
module xilinx_fifo_sync
    import xilinx_primitive_pkg::*;
#(
    parameter int    DATA_WIDTH              = 8,
    parameter int    DEPTH                   = 512,
    parameter int    ALMOST_EMPTY_OFFSET     = 4,
    parameter int    ALMOST_FULL_OFFSET      = 4,
    parameter string FIRST_WORD_FALL_THROUGH = "FALSE",
    localparam int   CW                      = fifo_cw(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  WREN,
    input  logic                  RDEN,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOSTFULL,
    output logic                  ALMOSTEMPTY,
    output logic [CW-1:0]         WRCOUNT,
    output logic [CW-1:0]         RDCOUNT,
    output logic [CW-1:0]         DATACOUNT,
    output logic                  WRERR,
    output logic                  RDERR
);

    localparam int            AW      = CW - 1;
    localparam fifo_rd_mode_e RD_MODE = (FIRST_WORD_FALL_THROUGH == "TRUE") ? FIFO_FWFT : FIFO_STD;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AE_LVL  = CW'(ALMOST_EMPTY_OFFSET);
    localparam logic [CW-1:0] AF_LVL  = CW'(DEPTH - ALMOST_FULL_OFFSET);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("xilinx_fifo_sync: DEPTH must be a power of two >= 2");
    end
    if ((ALMOST_EMPTY_OFFSET >= DEPTH) || (ALMOST_FULL_OFFSET >= DEPTH)) begin : g_bad_offset
        $error("xilinx_fifo_sync: almost offsets must be < DEPTH");
    end
    if ((FIRST_WORD_FALL_THROUGH != "TRUE") && (FIRST_WORD_FALL_THROUGH != "FALSE")) begin : g_bad_mode
        $error("xilinx_fifo_sync: FIRST_WORD_FALL_THROUGH must be TRUE or FALSE");
    end

    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] ram_rd_count;
    logic [CW-1:0] data_count;
    logic [CW-1:0] ram_level;
    logic [CW-1:0] next_count;
    logic          do_valid;
    logic          do_valid_next;
    logic          empty_next;
    logic          wr_acc;
    logic          pop_acc;
    logic          ram_re;
    logic          full_q;
    logic          empty_q;
    logic          afull_q;
    logic          aempty_q;
    logic          wrerr_q;
    logic          rderr_q;

    // In FWFT mode ram_rd_count runs ahead of rd_count by the word parked in DO.
    always_comb begin
        wr_acc        = WREN & ~full_q;
        pop_acc       = RDEN & ~empty_q;
        data_count    = wr_count - rd_count;
        ram_level     = wr_count - ram_rd_count;
        next_count    = data_count + CW'(wr_acc) - CW'(pop_acc);
        ram_re        = pop_acc;
        do_valid_next = do_valid;
        empty_next    = (next_count == '0);
        if (RD_MODE == FIFO_FWFT) begin
            ram_re        = (ram_level != '0) & (~do_valid | pop_acc);
            do_valid_next = ram_re | (do_valid & ~pop_acc);
            empty_next    = ~do_valid_next;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_count     <= '0;
            rd_count     <= '0;
            ram_rd_count <= '0;
            do_valid     <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
            wrerr_q      <= 1'b0;
            rderr_q      <= 1'b0;
        end else begin
            wr_count     <= wr_count + CW'(wr_acc);
            rd_count     <= rd_count + CW'(pop_acc);
            ram_rd_count <= ram_rd_count + CW'(ram_re);
            do_valid     <= do_valid_next;
            full_q       <= (next_count == DEPTH_C);
            empty_q      <= empty_next;
            afull_q      <= (next_count >= AF_LVL);
            aempty_q     <= (next_count <= AE_LVL);
            wrerr_q      <= WREN & full_q;
            rderr_q      <= RDEN & empty_q;
        end
    end

    xilinx_fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RSTN),
        .we    (wr_acc),
        .waddr (wr_count[AW-1:0]),
        .wdata (DI),
        .re    (ram_re),
        .raddr (ram_rd_count[AW-1:0]),
        .rdata (DO)
    );

    assign FULL        = full_q;
    assign EMPTY       = empty_q;
    assign ALMOSTFULL  = afull_q;
    assign ALMOSTEMPTY = aempty_q;
    assign WRCOUNT     = wr_count;
    assign RDCOUNT     = rd_count;
    assign DATACOUNT   = data_count;
    assign WRERR       = wrerr_q;
    assign RDERR       = rderr_q;

endmodule

// File: tb/tb_xilinx_fifo_sync.sv
// Random and directed stimulus on standard and FWFT instances, checked against a queue model.
module tb_xilinx_fifo_sync;

    logic       CLK;
    logic       RSTN;
    logic [7:0] DI;
    logic       WREN;
    logic       RDEN;

    logic [7:0] dout     [2];
    logic       full     [2];
    logic       empty    [2];
    logic       afull    [2];
    logic       aempty   [2];
    logic [4:0] wrcount  [2];
    logic [4:0] rdcount  [2];
    logic [4:0] dcount   [2];
    logic       wrerr    [2];
    logic       rderr    [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: std keeps one queue; FWFT keeps RAM queue plus the word visible on DO.
    byte unsigned q_s[$];
    byte unsigned r_f[$];
    bit           val_f;
    int           do_m   [2];
    int           wrc_m  [2];
    int           rdc_m  [2];
    bit           werr_m [2];
    bit           rerr_m [2];

    xilinx_fifo_sync #(
        .DATA_WIDTH (8), .DEPTH (16), .ALMOST_EMPTY_OFFSET (4),
        .ALMOST_FULL_OFFSET (4), .FIRST_WORD_FALL_THROUGH ("FALSE")
    ) u_std (
        .CLK (CLK), .RSTN (RSTN), .DI (DI), .WREN (WREN), .RDEN (RDEN),
        .DO (dout[0]), .FULL (full[0]), .EMPTY (empty[0]),
        .ALMOSTFULL (afull[0]), .ALMOSTEMPTY (aempty[0]),
        .WRCOUNT (wrcount[0]), .RDCOUNT (rdcount[0]), .DATACOUNT (dcount[0]),
        .WRERR (wrerr[0]), .RDERR (rderr[0])
    );

    xilinx_fifo_sync #(
        .DATA_WIDTH (8), .DEPTH (16), .ALMOST_EMPTY_OFFSET (4),
        .ALMOST_FULL_OFFSET (4), .FIRST_WORD_FALL_THROUGH ("TRUE")
    ) u_fwft (
        .CLK (CLK), .RSTN (RSTN), .DI (DI), .WREN (WREN), .RDEN (RDEN),
        .DO (dout[1]), .FULL (full[1]), .EMPTY (empty[1]),
        .ALMOSTFULL (afull[1]), .ALMOSTEMPTY (aempty[1]),
        .WRCOUNT (wrcount[1]), .RDCOUNT (rdcount[1]), .DATACOUNT (dcount[1]),
        .WRERR (wrerr[1]), .RDERR (rderr[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q_s.delete();
        r_f.delete();
        val_f = 1'b0;
        for (int m = 0; m < 2; m++) begin
            do_m[m]   = 0;
            wrc_m[m]  = 0;
            rdc_m[m]  = 0;
            werr_m[m] = 1'b0;
            rerr_m[m] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit w, input bit r, input byte unsigned d);
        int  n;
        bit  wa;
        bit  ra;
        bit  pre;
        n = q_s.size();
        wa = w && (n < 16);
        ra = r && (n > 0);
        werr_m[0] = w && (n == 16);
        rerr_m[0] = r && (n == 0);
        if (ra) do_m[0] = q_s.pop_front();
        if (wa) q_s.push_back(d);
        wrc_m[0] = (wrc_m[0] + int'(wa)) % 32;
        rdc_m[0] = (rdc_m[0] + int'(ra)) % 32;

        n = r_f.size() + int'(val_f);
        wa = w && (n < 16);
        ra = r && val_f;
        pre = (r_f.size() > 0) && (!val_f || ra);
        werr_m[1] = w && (n == 16);
        rerr_m[1] = r && !val_f;
        if (ra) val_f = 1'b0;
        if (pre) begin
            do_m[1] = r_f.pop_front();
            val_f = 1'b1;
        end
        if (wa) r_f.push_back(d);
        wrc_m[1] = (wrc_m[1] + int'(wa)) % 32;
        rdc_m[1] = (rdc_m[1] + int'(ra)) % 32;
    endtask

    task automatic check_all(input bit force_do);
        int    cnt;
        bit    emp;
        string p;
        for (int m = 0; m < 2; m++) begin
            p   = (m == 0) ? "std." : "fwft.";
            cnt = (m == 0) ? q_s.size() : (r_f.size() + int'(val_f));
            emp = (m == 0) ? (cnt == 0) : !val_f;
            chk_eq({p, "datacount"},   32'(dcount[m]),  32'(cnt));
            chk_eq({p, "full"},        32'(full[m]),    32'(cnt == 16));
            chk_eq({p, "empty"},       32'(empty[m]),   32'(emp));
            chk_eq({p, "almostfull"},  32'(afull[m]),   32'(cnt >= 12));
            chk_eq({p, "almostempty"}, 32'(aempty[m]),  32'(cnt <= 4));
            chk_eq({p, "wrcount"},     32'(wrcount[m]), 32'(wrc_m[m]));
            chk_eq({p, "rdcount"},     32'(rdcount[m]), 32'(rdc_m[m]));
            chk_eq({p, "wrerr"},       32'(wrerr[m]),   32'(werr_m[m]));
            chk_eq({p, "rderr"},       32'(rderr[m]),   32'(rerr_m[m]));
            if (m == 0 || !emp || force_do)
                chk_eq({p, "do"}, 32'(dout[m]), 32'(do_m[m]));
        end
    endtask

    task automatic step(input bit w, input bit r, input byte unsigned d);
        @(negedge CLK);
        WREN = w;
        RDEN = r;
        DI   = d;
        @(posedge CLK);
        model_edge(w, r, d);
        #1;
        check_all(1'b0);
    endtask

    initial begin
        int pw;
        int pr;
        RSTN = 1'b0;
        WREN = 1'b0;
        RDEN = 1'b0;
        DI   = 8'h00;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all(1'b1);
        @(negedge CLK);
        RSTN = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'h10);
        step(1'b0, 1'b0, 8'h00);

        // Drain in order, then one rejected pop.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Single-word latency, then pop it.
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Concurrent write+pop at level 8.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 8'($urandom));

        // Asynchronous reset mid-burst at 10 words; requests during reset are ignored.
        step(1'b1, 1'b0, 8'h3C);
        step(1'b1, 1'b0, 8'h3D);
        #2;
        RSTN = 1'b0;
        model_reset();
        #1;
        check_all(1'b1);
        WREN = 1'b1;
        RDEN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        WREN = 1'b0;
        RDEN = 1'b0;
        #1;
        check_all(1'b1);

        // Random traffic with a different write/read bias per block.
        for (int b = 0; b < 10; b++) begin
            pw = $urandom_range(20, 80);
            pr = $urandom_range(20, 80);
            for (int i = 0; i < 1000; i++)
                step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
